// File: rtl/soc_run_monitor.sv
// -----------------------------------------------------------------------------
// soc_run_monitor
// End-of-run monitor for multi-core (lockstep / TMR) SoC builds. It watches
// each core's completion flag, result word and fetch address. It reports run
// completion, per-core stalls and a global timeout. It also produces a
// bitwise-majority voted result and a per-core disagreement mask.
//
// Ports
//   clk_i            clock, rising edge
//   rst_ni           asynchronous active-low reset
//   start_i          start/restart a run (accepted in IDLE and FINISH only)
//   mem_flag_i       per-core completion flag, core k owns slice k, nonzero = done
//   mem_result_i     per-core result word
//   instr_addr_i     per-core fetch address
//   busy_o           high while running or checking
//   done_o           run finished, held until the next start_i
//   timeout_o        run ended by timeout (valid while done_o)
//   core_done_o      sticky per-core completion
//   stall_o          sticky per-core stall detect
//   result_o         bitwise-majority voted result (valid while done_o)
//   mismatch_o       any core disagrees with result_o
//   mismatch_mask_o  bit k = core k result differs from result_o
//   cycles_o         RUN cycles elapsed, saturating
// -----------------------------------------------------------------------------
module soc_run_monitor #(
    parameter int NUM_CORES      = 3,
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int CNT_W          = 20,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int STALL_CYCLES   = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic [NUM_CORES*DATA_W-1:0]   mem_flag_i,
    input  logic [NUM_CORES*DATA_W-1:0]   mem_result_i,
    input  logic [NUM_CORES*ADDR_W-1:0]   instr_addr_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          timeout_o,
    output logic [NUM_CORES-1:0]          core_done_o,
    output logic [NUM_CORES-1:0]          stall_o,
    output logic [DATA_W-1:0]             result_o,
    output logic                          mismatch_o,
    output logic [NUM_CORES-1:0]          mismatch_mask_o,
    output logic [CNT_W-1:0]              cycles_o
);

    localparam int VCW = $clog2(NUM_CORES + 1);
    localparam logic [VCW-1:0] VOTE_HALF = VCW'(NUM_CORES / 2);
    localparam int SCW = $clog2(STALL_CYCLES);
    localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    state_t                         state_r, state_next_s;
    logic                           timeout_hit_s;
    logic                           clear_s;
    logic [NUM_CORES-1:0]           flag_hit_s;
    logic [NUM_CORES-1:0]           complete_now_s;
    logic                           all_done_s;
    logic [DATA_W-1:0]              vote_s;
    logic [NUM_CORES-1:0]           mask_s;
    logic [NUM_CORES-1:0][SCW-1:0]  stall_cnt_r, stall_cnt_next_s;
    logic [NUM_CORES-1:0]           stall_hit_s;
    logic [NUM_CORES*ADDR_W-1:0]    prev_addr_r;
    logic [NUM_CORES*DATA_W-1:0]    latched_res_r;
    logic [NUM_CORES-1:0]           core_done_r, stall_r, mask_r;
    logic [CNT_W-1:0]               cycles_r;
    logic [DATA_W-1:0]              result_r;
    logic                           busy_r, done_r, timeout_r, mismatch_r;

    // Bit i of the vote is set when a strict majority of cores have bit i set;
    // an even split resolves to 0.
    function automatic logic [DATA_W-1:0] vote_majority(input logic [NUM_CORES*DATA_W-1:0] res);
        logic [VCW-1:0] ones;
        vote_majority = {DATA_W{1'b0}};
        for (int i = 0; i < DATA_W; i++) begin
            ones = {VCW{1'b0}};
            for (int k = 0; k < NUM_CORES; k++) begin
                ones = ones + VCW'(res[k*DATA_W + i]);
            end
            vote_majority[i] = (ones > VOTE_HALF);
        end
    endfunction

    // Per-core completion detection, clear request and result voting.
    always_comb begin
        flag_hit_s = {NUM_CORES{1'b0}};
        mask_s     = {NUM_CORES{1'b0}};
        for (int k = 0; k < NUM_CORES; k++) begin
            flag_hit_s[k] = |mem_flag_i[k*DATA_W +: DATA_W];
        end
        if (state_r == ST_RUN) begin
            complete_now_s = flag_hit_s & ~core_done_r;
        end else begin
            complete_now_s = {NUM_CORES{1'b0}};
        end
        all_done_s = &(core_done_r | complete_now_s);
        clear_s    = start_i && ((state_r == ST_IDLE) || (state_r == ST_FINISH));
        vote_s     = vote_majority(latched_res_r);
        for (int k = 0; k < NUM_CORES; k++) begin
            mask_s[k] = (latched_res_r[k*DATA_W +: DATA_W] != vote_s);
        end
    end

    // Next-state logic; completion is tested before timeout so it wins a tie.
    always_comb begin
        state_next_s  = state_r;
        timeout_hit_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (all_done_s) begin
                    state_next_s = ST_CHECK;
                end else if (cycles_r == TIMEOUT_LAST) begin
                    state_next_s  = ST_FINISH;
                    timeout_hit_s = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_CHECK: begin
                state_next_s = ST_FINISH;
            end
            ST_FINISH: begin
                if (start_i) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_FINISH;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Stall counters: restart on address change or once the core is done.
    always_comb begin
        stall_cnt_next_s = stall_cnt_r;
        stall_hit_s      = {NUM_CORES{1'b0}};
        for (int k = 0; k < NUM_CORES; k++) begin
            if ((instr_addr_i[k*ADDR_W +: ADDR_W] != prev_addr_r[k*ADDR_W +: ADDR_W]) ||
                core_done_r[k] || complete_now_s[k]) begin
                stall_cnt_next_s[k] = {SCW{1'b0}};
            end else if (stall_cnt_r[k] != STALL_LAST) begin
                stall_cnt_next_s[k] = stall_cnt_r[k] + {{(SCW-1){1'b0}}, 1'b1};
            end else begin
                stall_cnt_next_s[k] = stall_cnt_r[k];
            end
            stall_hit_s[k] = (stall_cnt_next_s[k] == STALL_LAST);
        end
    end

    // Address history (always sampled) and stall tracking during RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_addr_r <= {(NUM_CORES*ADDR_W){1'b0}};
            stall_cnt_r <= {(NUM_CORES*SCW){1'b0}};
            stall_r     <= {NUM_CORES{1'b0}};
        end else begin
            prev_addr_r <= instr_addr_i;
            if (clear_s) begin
                stall_cnt_r <= {(NUM_CORES*SCW){1'b0}};
                stall_r     <= {NUM_CORES{1'b0}};
            end else if (state_r == ST_RUN) begin
                stall_cnt_r <= stall_cnt_next_s;
                stall_r     <= stall_r | stall_hit_s;
            end
        end
    end

    // Run datapath: cycle count, result capture, vote registration.
    // The counter is frozen on the timeout exit so it reports the exact
    // cycle at which the run was abandoned.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles_r      <= {CNT_W{1'b0}};
            core_done_r   <= {NUM_CORES{1'b0}};
            latched_res_r <= {(NUM_CORES*DATA_W){1'b0}};
            timeout_r     <= 1'b0;
            result_r      <= {DATA_W{1'b0}};
            mask_r        <= {NUM_CORES{1'b0}};
            mismatch_r    <= 1'b0;
        end else if (clear_s) begin
            cycles_r      <= {CNT_W{1'b0}};
            core_done_r   <= {NUM_CORES{1'b0}};
            latched_res_r <= {(NUM_CORES*DATA_W){1'b0}};
            timeout_r     <= 1'b0;
            result_r      <= {DATA_W{1'b0}};
            mask_r        <= {NUM_CORES{1'b0}};
            mismatch_r    <= 1'b0;
        end else if (state_r == ST_RUN) begin
            if (!timeout_hit_s && (cycles_r != CNT_MAX)) begin
                cycles_r <= cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            core_done_r <= core_done_r | complete_now_s;
            for (int k = 0; k < NUM_CORES; k++) begin
                if (complete_now_s[k]) begin
                    latched_res_r[k*DATA_W +: DATA_W] <= mem_result_i[k*DATA_W +: DATA_W];
                end
            end
            if (timeout_hit_s) begin
                timeout_r <= 1'b1;
            end
        end else if (state_r == ST_CHECK) begin
            result_r   <= vote_s;
            mask_r     <= mask_s;
            mismatch_r <= |mask_s;
        end
    end

    // Registered busy/done flags derived from the upcoming state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_RUN) || (state_next_s == ST_CHECK);
            done_r <= (state_next_s == ST_FINISH);
        end
    end

    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign timeout_o       = timeout_r;
    assign core_done_o     = core_done_r;
    assign stall_o         = stall_r;
    assign result_o        = result_r;
    assign mismatch_o      = mismatch_r;
    assign mismatch_mask_o = mask_r;
    assign cycles_o        = cycles_r;

endmodule

// File: tb/tb_soc_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_soc_run_monitor
// Directed bench for soc_run_monitor (3 cores, 32-bit words, timeout 1000,
// stall threshold 64). Cycle 0 is the cycle right after the edge that accepts
// start_i; inputs for cycle c are driven just after edge c.
// -----------------------------------------------------------------------------
module tb_soc_run_monitor;

    localparam int NC = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 20;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [NC*DW-1:0]   mem_flag;
    logic [NC*DW-1:0]   mem_result;
    logic [NC*AW-1:0]   instr_addr;
    logic               busy;
    logic               done;
    logic               timeout;
    logic [NC-1:0]      core_done;
    logic [NC-1:0]      stall;
    logic [DW-1:0]      result;
    logic               mismatch;
    logic [NC-1:0]      mismatch_mask;
    logic [CW-1:0]      cycles;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int gcyc     = 0;
    logic freeze0 = 1'b0;

    soc_run_monitor #(
        .NUM_CORES      (NC),
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .CNT_W          (CW),
        .TIMEOUT_CYCLES (1000),
        .STALL_CYCLES   (64)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .mem_flag_i      (mem_flag),
        .mem_result_i    (mem_result),
        .instr_addr_i    (instr_addr),
        .busy_o          (busy),
        .done_o          (done),
        .timeout_o       (timeout),
        .core_done_o     (core_done),
        .stall_o         (stall),
        .result_o        (result),
        .mismatch_o      (mismatch),
        .mismatch_mask_o (mismatch_mask),
        .cycles_o        (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every core's address moves each cycle unless core 0 is frozen at 0x80.
    task automatic drive_addr();
        for (int k = 0; k < NC; k++) begin
            instr_addr[k*AW +: AW] = 32'h1000_0000 + 32'(k) * 32'h0010_0000 + 32'(gcyc) * 32'd4;
        end
        if (freeze0) begin
            instr_addr[0 +: AW] = 32'h0000_0080;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc  = cyc + 1;
        gcyc = gcyc + 1;
        drive_addr();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) begin
            step();
        end
    endtask

    task automatic set_flag(input int k, input logic [31:0] v);
        mem_flag[k*DW +: DW] = v;
    endtask

    task automatic set_result(input int k, input logic [31:0] v);
        mem_result[k*DW +: DW] = v;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        mem_flag   = '0;
        mem_result = '0;
        freeze0    = 1'b0;
        drive_addr();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic begin_run();
        start = 1'b1;
        step();
        start = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        // ---- Test 1: all cores agree, flags at cycle 40 ----
        apply_reset();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_cycles", 64'(cycles), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        for (int k = 0; k < NC; k++) set_result(k, 32'h0000_002A);
        begin_run();
        check_eq("t1_busy_c0", 64'(busy), 64'd1);
        check_eq("t1_cycles_c0", 64'(cycles), 64'd0);
        run_to(40);
        for (int k = 0; k < NC; k++) set_flag(k, 32'd1);
        step();
        check_eq("t1_done_c41", 64'(done), 64'd0);
        check_eq("t1_busy_c41", 64'(busy), 64'd1);
        step();
        check_eq("t1_done_c42", 64'(done), 64'd1);
        check_eq("t1_result", 64'(result), 64'h2A);
        check_eq("t1_mismatch", 64'(mismatch), 64'd0);
        check_eq("t1_timeout", 64'(timeout), 64'd0);
        check_eq("t1_cycles", 64'(cycles), 64'd41);
        check_eq("t1_core_done", 64'(core_done), 64'h7);
        check_eq("t1_busy_end", 64'(busy), 64'd0);
        check_eq("t1_stall", 64'(stall), 64'd0);

        // ---- Test 2: core 1 disagrees, staggered flags, ignored start/changes ----
        apply_reset();
        set_result(0, 32'h0000_002A);
        set_result(1, 32'h0000_002B);
        set_result(2, 32'h0000_002A);
        begin_run();
        run_to(25);
        start = 1'b1;
        step();
        start = 1'b0;
        run_to(30);
        set_flag(0, 32'h0000_0100);
        check_eq("t2_cd_c30", 64'(core_done), 64'd0);
        step();
        check_eq("t2_cd_c31", 64'(core_done), 64'h1);
        run_to(35);
        set_flag(1, 32'h8000_0000);
        run_to(40);
        set_result(0, 32'h0000_00FF);
        run_to(50);
        set_flag(2, 32'd1);
        step();
        check_eq("t2_done_c51", 64'(done), 64'd0);
        step();
        check_eq("t2_done_c52", 64'(done), 64'd1);
        check_eq("t2_result", 64'(result), 64'h2A);
        check_eq("t2_mask", 64'(mismatch_mask), 64'h2);
        check_eq("t2_mismatch", 64'(mismatch), 64'd1);
        check_eq("t2_cycles", 64'(cycles), 64'd51);

        // ---- Test 3: core 2 never flags -> timeout ----
        apply_reset();
        set_result(0, 32'h0000_0011);
        set_result(1, 32'h0000_0011);
        begin_run();
        run_to(20);
        set_flag(0, 32'd1);
        set_flag(1, 32'd1);
        run_to(999);
        check_eq("t3_done_c999", 64'(done), 64'd0);
        check_eq("t3_busy_c999", 64'(busy), 64'd1);
        step();
        check_eq("t3_done", 64'(done), 64'd1);
        check_eq("t3_timeout", 64'(timeout), 64'd1);
        check_eq("t3_core_done", 64'(core_done), 64'h3);
        check_eq("t3_cycles", 64'(cycles), 64'd999);
        check_eq("t3_result", 64'(result), 64'd0);
        check_eq("t3_mismatch", 64'(mismatch), 64'd0);
        check_eq("t3_mask", 64'(mismatch_mask), 64'd0);

        // ---- Test 4: core 0 address frozen from cycle 10 ----
        apply_reset();
        begin_run();
        run_to(10);
        freeze0 = 1'b1;
        drive_addr();
        run_to(73);
        check_eq("t4_stall_c73", 64'(stall), 64'd0);
        step();
        check_eq("t4_stall_c74", 64'(stall), 64'h1);
        check_eq("t4_busy_c74", 64'(busy), 64'd1);
        run_to(200);
        check_eq("t4_stall_c200", 64'(stall), 64'h1);
        check_eq("t4_done_c200", 64'(done), 64'd0);
        freeze0 = 1'b0;

        // ---- Test 5: last flag on cycle 999, then restart from FINISH ----
        apply_reset();
        for (int k = 0; k < NC; k++) set_result(k, 32'h0000_0055);
        begin_run();
        run_to(100);
        set_flag(0, 32'd1);
        set_flag(1, 32'd1);
        run_to(999);
        set_flag(2, 32'd1);
        step();
        check_eq("t5_done_c1000", 64'(done), 64'd0);
        step();
        check_eq("t5_done", 64'(done), 64'd1);
        check_eq("t5_timeout", 64'(timeout), 64'd0);
        check_eq("t5_cycles", 64'(cycles), 64'd1000);
        check_eq("t5_result", 64'(result), 64'h55);
        mem_flag = '0;
        begin_run();
        check_eq("t5_rs_busy", 64'(busy), 64'd1);
        check_eq("t5_rs_done", 64'(done), 64'd0);
        check_eq("t5_rs_core_done", 64'(core_done), 64'd0);
        check_eq("t5_rs_cycles0", 64'(cycles), 64'd0);
        check_eq("t5_rs_result", 64'(result), 64'd0);
        step();
        check_eq("t5_rs_cycles1", 64'(cycles), 64'd1);

        // ---- Test 6: reset mid-run, then a normal run with a mixed vote ----
        apply_reset();
        begin_run();
        run_to(5);
        set_flag(0, 32'd1);
        run_to(20);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_busy", 64'(busy), 64'd0);
        check_eq("t6_rst_cycles", 64'(cycles), 64'd0);
        check_eq("t6_rst_core_done", 64'(core_done), 64'd0);
        check_eq("t6_rst_done", 64'(done), 64'd0);
        mem_flag = '0;
        #1;
        rst_n = 1'b1;
        step();
        set_result(0, 32'h0000_000F);
        set_result(1, 32'h0000_0033);
        set_result(2, 32'h0000_0055);
        begin_run();
        run_to(5);
        for (int k = 0; k < NC; k++) set_flag(k, 32'd1);
        step();
        step();
        check_eq("t6_done", 64'(done), 64'd1);
        check_eq("t6_result", 64'(result), 64'h17);
        check_eq("t6_mask", 64'(mismatch_mask), 64'h7);
        check_eq("t6_mismatch", 64'(mismatch), 64'd1);
        check_eq("t6_cycles", 64'(cycles), 64'd6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
